wb_sccb_ctrl: RTL and testbench

//  Wishbone-slave SCCB (I2C-like) write master that configures the OV7670 camera

---
 rtl/wb_sccb_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_wb_sccb_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sccb_ctrl.sv
// Wishbone slave that turns one CMD write into a 3-phase SCCB write.
// Phases: device ID, register address, value.
module wb_sccb_ctrl #(
    parameter int          wb_dat_width = 32,
    parameter int          wb_adr_width = 32,
    parameter int          CLK_DIV      = 125,
    parameter logic [7:0]  DEV_ID       = 8'h42
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [wb_adr_width-1:0] wb_adr_i,
    input  logic [wb_dat_width-1:0] wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_sel_i,
    output logic [wb_dat_width-1:0] wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    sio_c,
    output logic                    sio_d_o,
    output logic                    sio_d_oe
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [2:0]    state;
    logic [DW-1:0] div;
    logic [1:0]    qtr;
    logic [4:0]    bit_idx;
    logic [7:0]    reg_addr;
    logic [7:0]    reg_val;
    logic          busy;
    logic          done;
    logic          err;
    logic          ack_reg;

    logic [7:0]    adr;
    logic          req;
    logic          wr_cmd;
    logic          start;
    logic          tick;
    logic          ninth;
    logic [26:0]   frame;
    logic          c_nxt;
    logic          d_nxt;
    logic          oe_nxt;
    logic          unused;

    assign unused = ^{wb_sel_i, wb_adr_i[wb_adr_width-1:8],
                      wb_dat_i[wb_dat_width-1:16]};

    assign adr      = wb_adr_i[7:0];
    assign req      = wb_cyc_i & wb_stb_i & ~ack_reg;
    assign wr_cmd   = req & wb_we_i & (adr == 8'h00);
    assign start    = wr_cmd & (state == S_IDLE);
    assign tick     = (div == DIV_LAST);
    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg  <= 1'b0;
            wb_dat_o <= '0;
            reg_addr <= 8'h00;
            reg_val  <= 8'h00;
            err      <= 1'b0;
        end else begin
            ack_reg <= wb_cyc_i & wb_stb_i & ~ack_reg;
            if (req && !wb_we_i) begin
                case (adr)
                    8'h00:   wb_dat_o <= wb_dat_width'({reg_addr, reg_val});
                    8'h04:   wb_dat_o <= wb_dat_width'({err, done, busy});
                    default: wb_dat_o <= '0;
                endcase
            end
            if (req && wb_we_i && adr == 8'h04)
                err <= 1'b0;
            if (start) begin
                reg_addr <= wb_dat_i[15:8];
                reg_val  <= wb_dat_i[7:0];
            end else if (wr_cmd) begin
                err <= 1'b1;
            end
        end
    end

    // Quarter-bit sequencer; busy spans START..GAP inclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            div     <= '0;
            qtr     <= 2'd0;
            bit_idx <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            state   <= S_START;
            div     <= '0;
            qtr     <= 2'd0;
            bit_idx <= 5'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (state != S_IDLE) begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                qtr <= qtr + 2'd1;
                case (state)
                    S_START: begin
                        if (qtr == 2'd1) begin
                            state <= S_BIT;
                            qtr   <= 2'd0;
                        end
                    end
                    S_BIT: begin
                        if (qtr == 2'd3) begin
                            if (bit_idx == 5'd26) begin
                                state   <= S_STOP;
                                bit_idx <= 5'd0;
                            end else begin
                                bit_idx <= bit_idx + 5'd1;
                            end
                        end
                    end
                    S_STOP: begin
                        if (qtr == 2'd2) begin
                            state <= S_GAP;
                            qtr   <= 2'd0;
                        end
                    end
                    S_GAP: begin
                        if (qtr == 2'd3) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign frame = {DEV_ID, 1'b1, reg_addr, 1'b1, reg_val, 1'b1};
    assign ninth = (bit_idx == 5'd8) || (bit_idx == 5'd17) ||
                   (bit_idx == 5'd26);

    always_comb begin
        c_nxt  = 1'b1;
        d_nxt  = 1'b1;
        oe_nxt = 1'b1;
        case (state)
            S_START: begin
                d_nxt = 1'b0;
                c_nxt = (qtr == 2'd0);
            end
            S_BIT: begin
                c_nxt = qtr[1];
                if (ninth)
                    oe_nxt = 1'b0;
                else
                    d_nxt = frame[5'd26 - bit_idx];
            end
            S_STOP: begin
                c_nxt = (qtr != 2'd0);
                d_nxt = (qtr == 2'd2);
            end
            default: ;
        endcase
    end

    // Registered line drivers keep sio_c free of decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sio_c    <= 1'b1;
            sio_d_o  <= 1'b1;
            sio_d_oe <= 1'b1;
        end else begin
            sio_c    <= c_nxt;
            sio_d_o  <= d_nxt;
            sio_d_oe <= oe_nxt;
        end
    end

endmodule

// File: tb/tb_wb_sccb_ctrl.sv
// Directed bench for wb_sccb_ctrl with CLK_DIV=4 (468-cycle transfers).
// Register table vectors plus hand-timed transfer sequences.
module tb_wb_sccb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_sel_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        sio_c;
    logic        sio_d_o;
    logic        sio_d_oe;

    wb_sccb_ctrl #(
        .wb_dat_width(32),
        .wb_adr_width(32),
        .CLK_DIV(4),
        .DEV_ID(8'h42)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .sio_c(sio_c),
        .sio_d_o(sio_d_o),
        .sio_d_oe(sio_d_oe)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int last_ack = 0;

    // Line monitor: bits on sio_c rises, data moves while clock high, clock edges.
    logic        mon_clr = 1'b0;
    logic        pc = 1'b1;
    logic        pd = 1'b1;
    int          rises = 0;
    int          dchg = 0;
    int          cedges = 0;
    logic [31:0] bitv = '0;
    logic [31:0] oev = '1;

    always @(negedge clk) begin
        if (mon_clr) begin
            rises = 0;
            dchg = 0;
            cedges = 0;
            bitv = '0;
            oev = '1;
        end else begin
            if (!pc && sio_c) begin
                if (rises < 32) begin
                    bitv[rises] = sio_d_o;
                    oev[rises] = sio_d_oe;
                end
                rises++;
            end
            if (pc && sio_c && pd != sio_d_o) dchg++;
            if (pc != sio_c) cedges++;
        end
        pc = sio_c;
        pd = sio_d_o;
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
        logic        chk;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [31:0] exp,
                       input logic chk, input string name);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat;
        v.exp = exp; v.chk = chk; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic goto(input int n);
        while (cyc_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, output logic [31:0] rd,
                       output int lat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!wb_ack_o && lat < 8);
        if (!wb_ack_o) begin
            total_cnt++;
            $display("FAIL bus_ack: got no ack expected ack adr 0x%0h", adr);
        end
        rd = wb_dat_o;
        last_ack = cyc_cnt;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        int lat;
        bus(1'b1, adr, dat, rd, lat);
    endtask

    task automatic rd_chk(input logic [31:0] adr, input logic [31:0] exp,
                          input string name);
        logic [31:0] rd;
        int lat;
        bus(1'b0, adr, 32'h0, rd, lat);
        check(name, rd, exp);
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(posedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic do_reset(input logic chk);
        rst = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (chk) begin
            check("rst_lines", {29'b0, sio_c, sio_d_o, sio_d_oe}, 32'h7);
            check("rst_dat_o", wb_dat_o, 32'h0);
            check("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] a, input logic [7:0] v,
                               input string tag);
        logic [7:0]  b0, b1, b2;
        logic [26:0] oe_exp;
        for (int j = 0; j < 8; j++) begin
            b0[7-j] = bitv[j];
            b1[7-j] = bitv[9+j];
            b2[7-j] = bitv[18+j];
        end
        oe_exp = '1;
        oe_exp[8] = 1'b0;
        oe_exp[17] = 1'b0;
        oe_exp[26] = 1'b0;
        check({tag, "_dev"}, {24'b0, b0}, 32'h42);
        check({tag, "_addr"}, {24'b0, b1}, {24'b0, a});
        check({tag, "_val"}, {24'b0, b2}, {24'b0, v});
        check({tag, "_oe"}, {5'b0, oev[26:0]}, {5'b0, oe_exp});
        check({tag, "_ack_d"}, {29'b0, bitv[8], bitv[17], bitv[26]}, 32'h7);
        check({tag, "_rises"}, rises, 28);
        check({tag, "_start_stop"}, dchg, 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a;
        int lat;
        int cmd_edge;
        logic [31:0] rd;

        // Reset state and register map
        do_reset(1'b1);
        mon_clear();
        add(1'b0, 32'h04, 32'h0, 32'h0, 1'b1, "stat_rst");
        add(1'b0, 32'h00, 32'h0, 32'h0, 1'b1, "cmd_rst");
        add(1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "rd_unmapped");
        add(1'b1, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, "wr_unmapped");
        add(1'b0, 32'h04, 32'h0, 32'h0, 1'b1, "stat_after_w10");
        add(1'b1, 32'h00, 32'h0000ABCD, 32'h0, 1'b0, "cmd_abcd");
        add(1'b0, 32'h00, 32'h0, 32'h0000ABCD, 1'b1, "cmd_readback");
        add(1'b0, 32'h04, 32'h0, 32'h1, 1'b1, "stat_busy");
        add(1'b1, 32'h00, 32'h00005555, 32'h0, 1'b0, "cmd_while_busy");
        add(1'b0, 32'h00, 32'h0, 32'h0000ABCD, 1'b1, "cmd_kept");
        add(1'b0, 32'h04, 32'h0, 32'h5, 1'b1, "stat_err");
        add(1'b1, 32'h04, 32'h0, 32'h0, 1'b0, "err_clr");
        add(1'b0, 32'h04, 32'h0, 32'h1, 1'b1, "stat_cleared");
        add(1'b0, 32'h104, 32'h0, 32'h1, 1'b1, "stat_alias");
        cmd_edge = 0;
        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat, rd, lat);
            if (tbl[i].chk) check(tbl[i].name, rd, tbl[i].exp);
            if (tbl[i].name == "cmd_abcd") cmd_edge = last_ack;
        end
        goto(cmd_edge + 470);
        check_frame(8'hAB, 8'hCD, "t_abcd");
        rd_chk(32'h04, 32'h2, "t_abcd_done");

        // Basic transfer, ack latency and exact busy window
        do_reset(1'b0);
        mon_clear();
        bus(1'b1, 32'h00, 32'h1280, rd, lat);
        a = last_ack;
        check("ack_latency", lat, 1);
        goto(a + 467);
        rd_chk(32'h04, 32'h1, "busy_last_cycle");
        rd_chk(32'h04, 32'h2, "done_after");
        check_frame(8'h12, 8'h80, "t1280");

        // Command while busy is dropped and sets sticky err
        do_reset(1'b0);
        mon_clear();
        wr(32'h00, 32'h1104);
        a = last_ack;
        goto(a + 99);
        wr(32'h00, 32'h3A04);
        goto(a + 468);
        rd_chk(32'h04, 32'h6, "err_done_exact");
        check_frame(8'h11, 8'h04, "t1104");
        wr(32'h04, 32'h0);
        rd_chk(32'h04, 32'h2, "err_cleared");

        // Reset mid-transfer idles the lines at once
        do_reset(1'b0);
        wr(32'h00, 32'h1280);
        a = last_ack;
        goto(a + 199);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_lines", {29'b0, sio_c, sio_d_o, sio_d_oe}, 32'h7);
        rst = 1'b0;
        mon_clear();
        repeat (100) @(posedge clk);
        #1;
        check("midrst_quiet", cedges, 0);
        rd_chk(32'h04, 32'h0, "midrst_stat");

        // Back-to-back: next command sampled the edge after busy falls
        do_reset(1'b0);
        wr(32'h00, 32'h0102);
        a = last_ack;
        goto(a + 468);
        mon_clr = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = 1'b1;
        wb_adr_i = 32'h00;
        wb_dat_i = 32'h0304;
        @(posedge clk);
        #1;
        mon_clr = 1'b0;
        check("b2b_ack", {31'b0, wb_ack_o}, 32'h1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        check("b2b_pre", {31'b0, sio_d_o}, 32'h1);
        @(posedge clk);
        #1;
        check("b2b_start", {30'b0, sio_c, sio_d_o}, 32'h2);
        goto(a + 469 + 470);
        check_frame(8'h03, 8'h04, "t0304");
        rd_chk(32'h04, 32'h2, "b2b_stat");

        // Command landing on the edge busy falls is rejected
        do_reset(1'b0);
        wr(32'h00, 32'h0506);
        a = last_ack;
        goto(a + 467);
        wr(32'h00, 32'h0708);
        rd_chk(32'h04, 32'h6, "edge_cmd_rejected");
        rd_chk(32'h00, 32'h0506, "edge_cmd_kept");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
